// File: rtl/register_file.sv
// MIPS GPR file: 32x32, two combinational read ports, one write port (1-cycle write latency), r0 reads 0.
// Optional same-cycle write-to-read forwarding; no backpressure, a write is accepted every cycle.
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int NREG = 2 ** ADDR_W;

    logic              wr_hit;
    logic              byp_vld;
    logic [DATA_W-1:0] rd_arr [NREG];

    assign wr_hit = wr_en && (wr_addr != '0);

    // r0 has no flops; its read-mux leg is tied to zero.
    assign rd_arr[0] = '0;

    for (genvar g = 1; g < NREG; g++) begin : g_reg
        logic [DATA_W-1:0] reg_q;
        logic [DATA_W-1:0] reg_d;

        always_comb begin
            reg_d = reg_q;
            if (wr_hit && (wr_addr == ADDR_W'(g))) begin
                reg_d = wr_data;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                reg_q <= '0;
            end else begin
                reg_q <= reg_d;
            end
        end

        assign rd_arr[g] = reg_q;
    end

    // Forwarding is suppressed during reset since that write never lands.
    assign byp_vld = BYPASS && wr_hit && !reset;

    always_comb begin
        rs_data = rd_arr[rs_addr];
        rt_data = rd_arr[rt_addr];
        if (byp_vld && (rs_addr == wr_addr)) begin
            rs_data = wr_data;
        end
        if (byp_vld && (rt_addr == wr_addr)) begin
            rt_data = wr_data;
        end
    end

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

    logic        clk;
    logic        reset;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] nb_rs_data;
    logic [31:0] nb_rt_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    logic [31:0] model [32];

    register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut (
        .clk(clk), .reset(reset),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .reset(reset),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(nb_rs_data), .rt_data(nb_rt_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: architectural register contents, committed at each edge.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] <= 32'h0;
        end else if (wr_en && wr_addr != 5'd0) begin
            model[wr_addr] <= wr_data;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit fwd);
        if (a == 5'd0) return 32'h0;
        if (fwd && !reset && wr_en && wr_addr == a) return wr_data;
        return model[a];
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rs_byp", rs_data, exp_rd(rs_addr, 1'b1));
            chk("rt_byp", rt_data, exp_rd(rt_addr, 1'b1));
            chk("rs_nobyp", nb_rs_data, exp_rd(rs_addr, 1'b0));
            chk("rt_nobyp", nb_rt_data, exp_rd(rt_addr, 1'b0));
        end
    end

    task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb);
        @(posedge clk);
        #1;
        reset   = rst;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rs_addr = ra;
        rt_addr = rb;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rs_addr = '0; rt_addr = '0;

        // 1. reset, then every index reads zero on both ports
        drive(1, 1, 5'd4, 32'h5555_5555, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
            chk_en = 1'b1;
            @(negedge clk);
            chk("reset_rs", rs_data, 32'h0);
            chk("reset_rt", rt_data, 32'h0);
        end

        // 2. LUI-style write to r8, read back next cycle
        drive(0, 1, 5'd8, 32'h1234_0000, 5'd8, 5'd0);
        drive(0, 0, 5'd0, 32'h0, 5'd8, 5'd0);
        @(negedge clk);
        chk("r8_rs", rs_data, 32'h1234_0000);
        chk("r8_rt_zero", rt_data, 32'h0);
        chk("r8_nobyp", nb_rs_data, 32'h1234_0000);

        // 3. write to r0 ignored and not forwarded
        drive(0, 1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        @(negedge clk);
        chk("r0_fwd_rs", rs_data, 32'h0);
        chk("r0_fwd_rt", rt_data, 32'h0);
        drive(0, 0, 5'd0, 32'h0, 5'd0, 5'd8);
        @(negedge clk);
        chk("r0_rs", rs_data, 32'h0);
        chk("r0_r8_intact", rt_data, 32'h1234_0000);

        // 4. bypass vs. no bypass on both ports
        drive(0, 1, 5'd5, 32'h1111_1111, 5'd0, 5'd0);
        drive(0, 1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5);
        @(negedge clk);
        chk("byp_rs", rs_data, 32'hDEAD_BEEF);
        chk("byp_rt", rt_data, 32'hDEAD_BEEF);
        chk("nobyp_rs", nb_rs_data, 32'h1111_1111);
        chk("nobyp_rt", nb_rt_data, 32'h1111_1111);
        drive(0, 0, 5'd0, 32'h0, 5'd5, 5'd5);
        @(negedge clk);
        chk("r5_after_rs", nb_rs_data, 32'hDEAD_BEEF);
        chk("r5_after_rt", nb_rt_data, 32'hDEAD_BEEF);

        // back-to-back writes to one index: last write wins
        drive(0, 1, 5'd9, 32'h0000_00AA, 5'd0, 5'd0);
        drive(0, 1, 5'd9, 32'h0000_00BB, 5'd0, 5'd0);
        drive(0, 0, 5'd0, 32'h0, 5'd9, 5'd9);
        @(negedge clk);
        chk("b2b_last_wins", rs_data, 32'h0000_00BB);

        // 5. reset drops the concurrent write and wipes the prior one
        drive(0, 1, 5'd31, 32'hABCD_0000, 5'd0, 5'd0);
        drive(1, 1, 5'd31, 32'h0000_0001, 5'd31, 5'd31);
        @(negedge clk);
        chk("rst_no_byp", rs_data, 32'hABCD_0000);
        drive(0, 0, 5'd0, 32'h0, 5'd31, 5'd8);
        @(negedge clk);
        chk("rst_r31", rs_data, 32'h0);
        chk("rst_r8", rt_data, 32'h0);

        // 6. random stream checked every cycle against the model
        for (int n = 0; n < 1000; n++) begin
            logic [4:0] wa;
            wa = (n % 3 == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                  wa, $urandom(),
                  ($urandom_range(0, 1) == 0) ? wa : 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)));
        end
        drive(0, 0, 5'd0, 32'h0, 5'd0, 5'd0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
